// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcodes, controller FSM encoding and data width
package alu_pkg;
  localparam int DW = 32;
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_NOT = 3'd2;
  localparam logic [2:0] ALU_AND = 3'd3;
  localparam logic [2:0] ALU_OR  = 3'd4;
  localparam logic [2:0] ALU_XOR = 3'd5;
  localparam logic [2:0] ALU_SLT = 3'd6;
  localparam logic [2:0] ALU_EQ  = 3'd7;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_RESP = 2'd2} state_t;
endpackage

// File: rtl/alu_share_ctrl_if.sv
// alu_share_ctrl_if: requester-side request/response bundle of the shared ALU controller
interface alu_share_ctrl_if import alu_pkg::*; #(parameter int NREQ = 2);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*DW-1:0] req_a;
  logic [NREQ*DW-1:0] req_b;
  logic [NREQ*3-1:0]  req_op;
  logic [NREQ-1:0]    resp_valid;
  logic [NREQ-1:0]    resp_ready;
  logic [DW-1:0]      resp_sum;
  logic               resp_overflow;
  modport master (output req_valid, req_a, req_b, req_op, resp_ready,
                  input  req_ready, resp_valid, resp_sum, resp_overflow);
  modport slave  (input  req_valid, req_a, req_b, req_op, resp_ready,
                  output req_ready, resp_valid, resp_sum, resp_overflow);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting after last_grant_i, with wrap
module rr_arbiter #(
  parameter int NREQ = 2,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_grant_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);
  // Scan farthest-first so the nearest requester after last_grant_i wins
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int i = NREQ; i >= 1; i--) begin
      if (req_i[(int'(last_grant_i) + i) % NREQ]) begin
        idx_o = IW'((int'(last_grant_i) + i) % NREQ);
        any_o = 1'b1;
      end
    end
    grant_o = any_o ? NREQ'(1) << idx_o : '0;
  end
endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sequencer sharing one combinational ALU among NREQ requesters
module alu_share_ctrl import alu_pkg::*; #(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_share_ctrl_if.slave bus,
  output logic [DW-1:0]   alu_r1_o,
  output logic [DW-1:0]   alu_r2_o,
  output logic [2:0]      alu_sub_o,
  output logic            alu_enable_o,
  input  logic [DW-1:0]   alu_sum_i,
  input  logic            alu_overflow_i
);
  localparam int IW = $clog2(NREQ);
  state_t          state_q, state_d;
  logic [IW-1:0]   last_q, last_d, owner_q, owner_d, widx;
  logic [NREQ-1:0] grant;
  logic            any, accept;
  logic [DW-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [2:0]      op_q, op_d;
  logic            ovf_q, ovf_d;
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i        (bus.req_valid),
    .last_grant_i (last_q),
    .grant_o      (grant),
    .idx_o        (widx),
    .any_o        (any)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= IW'(NREQ - 1);
      owner_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end
  always_comb begin
    accept         = state_q == ST_IDLE && any;
    bus.req_ready  = accept ? grant : '0;
    bus.resp_valid = state_q == ST_RESP ? NREQ'(1) << owner_q : '0;
    alu_enable_o   = state_q == ST_EXEC;
    last_d         = accept ? widx : last_q;
    owner_d        = accept ? widx : owner_q;
    a_d            = accept ? bus.req_a[int'(widx)*DW +: DW] : a_q;
    b_d            = accept ? bus.req_b[int'(widx)*DW +: DW] : b_q;
    op_d           = accept ? bus.req_op[int'(widx)*3 +: 3] : op_q;
    sum_d          = state_q == ST_EXEC ? alu_sum_i : sum_q;
    ovf_d          = state_q == ST_EXEC ? alu_overflow_i : ovf_q;
    state_d        = accept ? ST_EXEC :
                     state_q == ST_EXEC ? ST_RESP :
                     state_q == ST_RESP && bus.resp_ready[owner_q] ? ST_IDLE : state_q;
  end
  assign alu_r1_o          = a_q;
  assign alu_r2_o          = b_q;
  assign alu_sub_o         = op_q;
  assign bus.resp_sum      = sum_q;
  assign bus.resp_overflow = ovf_q;
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed and random checks of the shared-ALU controller against a transaction-level model
module tb_alu_share_ctrl;
  import alu_pkg::*;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] alu_r1, alu_r2, alu_sum;
  logic [2:0]  alu_sub;
  logic        alu_en, alu_ovf;
  int n_chk = 0;
  int n_err = 0;
  int last_m = N - 1;
  logic [N-1:0] last_rv;
  alu_share_ctrl_if #(.NREQ(N)) bus ();
  alu_share_ctrl #(.NREQ(N)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus.slave),
    .alu_r1_o       (alu_r1),
    .alu_r2_o       (alu_r2),
    .alu_sub_o      (alu_sub),
    .alu_enable_o   (alu_en),
    .alu_sum_i      (alu_sum),
    .alu_overflow_i (alu_ovf)
  );
  always #5 clk = ~clk;
  function automatic logic [32:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    logic [31:0] s = a + b;
    logic [31:0] d = a - b;
    logic so = (a[31] == b[31]) && (s[31] != a[31]);
    logic dov = (a[31] != b[31]) && (d[31] != a[31]);
    case (op)
      ALU_ADD: return {so, s};
      ALU_SUB: return {dov, d};
      ALU_NOT: return {1'b0, ~a};
      ALU_AND: return {1'b0, a & b};
      ALU_OR:  return {1'b0, a | b};
      ALU_XOR: return {1'b0, a ^ b};
      ALU_SLT: return {dov, 31'd0, $signed(a) < $signed(b)};
      ALU_EQ:  return {1'b0, 31'd0, a == b};
      default: return '0;
    endcase
  endfunction
  always_comb {alu_ovf, alu_sum} = alu_f(alu_r1, alu_r2, alu_sub);
  // Winner is the valid requester at the smallest circular distance past the last grant
  function automatic int pick(input logic [N-1:0] m, input int last);
    int best = -1;
    int bd = N;
    for (int i = 0; i < N; i++)
      if (m[i] && ((i - last - 1 + 2 * N) % N) < bd) begin
        bd = (i - last - 1 + 2 * N) % N;
        best = i;
      end
    return best;
  endfunction
  function automatic logic [N-1:0] oh(input int w);
    return w < 0 ? '0 : N'(1) << w;
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic set_req(input int r, input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    bus.req_valid[r] = v;
    bus.req_a[32*r +: 32] = a;
    bus.req_b[32*r +: 32] = b;
    bus.req_op[3*r +: 3] = op;
  endtask
  task automatic transact(input bit scramble, input int hold, output int w);
    logic [31:0] ea, eb;
    logic [2:0] eop;
    logic [32:0] ex;
    #1;
    w = pick(bus.req_valid, last_m);
    chk("idle_ready", bus.req_ready, oh(w));
    chk("idle_en", alu_en, 1'b0);
    if (w < 0) return;
    ea = bus.req_a[32*w +: 32];
    eb = bus.req_b[32*w +: 32];
    eop = bus.req_op[3*w +: 3];
    ex = alu_f(ea, eb, eop);
    @(posedge clk);
    @(negedge clk);
    chk("exec_en", alu_en, 1'b1);
    chk("exec_r1", alu_r1, ea);
    chk("exec_r2", alu_r2, eb);
    chk("exec_op", alu_sub, eop);
    chk("exec_ready", bus.req_ready, '0);
    chk("exec_rv", bus.resp_valid, '0);
    if (scramble)
      for (int r = 0; r < N; r++)
        set_req(r, bus.req_valid[r], $urandom, $urandom, 3'($urandom));
    @(posedge clk);
    @(negedge clk);
    last_rv = bus.resp_valid;
    chk("resp_rv", bus.resp_valid, oh(w));
    chk("resp_sum", bus.resp_sum, ex[31:0]);
    chk("resp_ovf", bus.resp_overflow, ex[32]);
    chk("resp_en", alu_en, 1'b0);
    chk("resp_ready", bus.req_ready, '0);
    for (int h = 0; h < hold; h++) begin
      bus.resp_ready = N'($urandom) & ~oh(w);
      @(posedge clk);
      @(negedge clk);
      chk("hold_rv", bus.resp_valid, oh(w));
      chk("hold_sum", bus.resp_sum, ex[31:0]);
      chk("hold_ready", bus.req_ready, '0);
    end
    bus.resp_ready = oh(w) | N'($urandom);
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = '0;
    last_m = w;
    chk("done_rv", bus.resp_valid, '0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  initial begin
    int w;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_op = '0;
    bus.resp_ready = '0;
    #1;
    chk("rst_ready", bus.req_ready, '0);
    chk("rst_rv", bus.resp_valid, '0);
    chk("rst_en", alu_en, 1'b0);
    chk("rst_r1", alu_r1, '0);
    chk("rst_sum", bus.resp_sum, '0);
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 1'b1, 32'h7FFFFFFF, 32'd1, ALU_ADD);
    transact(1'b0, 0, w);
    chk("add_sum", bus.resp_sum, 32'h80000000);
    chk("add_ovf", bus.resp_overflow, 1'b1);
    set_req(0, 1'b1, 32'd5, 32'd7, ALU_SUB);
    set_req(1, 1'b1, 32'hFFFFFFFF, 32'd1, ALU_SLT);
    for (int k = 1; k < 5; k++) begin
      transact(1'b0, 0, w);
      chk("rr_owner", last_rv, k % 2 ? 4'b0010 : 4'b0001);
      chk("rr_sum", bus.resp_sum, k % 2 ? 32'd1 : 32'hFFFFFFFE);
      if (k % 2 == 0) chk("rr_ovf", bus.resp_overflow, 1'b0);
    end
    bus.req_valid = '0;
    set_req(1, 1'b1, 32'h12345678, 32'h0000FFFF, ALU_XOR);
    transact(1'b0, 10, w);
    chk("bp_sum", bus.resp_sum, 32'h1234A987);
    bus.req_valid = '0;
    set_req(0, 1'b1, 32'hF0F0F0F0, 32'hFF00FF00, ALU_AND);
    transact(1'b1, 0, w);
    chk("and_sum", bus.resp_sum, 32'hF000F000);
    bus.req_valid = '0;
    set_req(0, 1'b1, 32'd1, 32'd2, ALU_ADD);
    @(posedge clk);
    @(negedge clk);
    chk("ar_exec_en", alu_en, 1'b1);
    bus.req_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("ar_en", alu_en, 1'b0);
    chk("ar_rv", bus.resp_valid, '0);
    chk("ar_r1", alu_r1, '0);
    chk("ar_op", alu_sub, '0);
    chk("ar_sum", bus.resp_sum, '0);
    chk("ar_ready", bus.req_ready, '0);
    @(negedge clk);
    rst_n = 1'b1;
    last_m = N - 1;
    set_req(1, 1'b1, 32'd3, 32'd3, ALU_EQ);
    transact(1'b0, 0, w);
    chk("ar_eq_owner", last_rv, 4'b0010);
    chk("ar_eq_sum", bus.resp_sum, 32'd1);
    bus.req_valid = '0;
    set_req(3, 1'b1, 32'd9, 32'd4, ALU_OR);
    transact(1'b0, 0, w);
    chk("wrap_pre", last_rv, 4'b1000);
    set_req(1, 1'b1, 32'd1, 32'd1, ALU_ADD);
    transact(1'b0, 0, w);
    chk("wrap_first", last_rv, 4'b0010);
    transact(1'b0, 0, w);
    chk("wrap_second", last_rv, 4'b1000);
    for (int t = 0; t < 60; t++) begin
      for (int r = 0; r < N; r++)
        set_req(r, 1'($urandom_range(0, 1)), $urandom, $urandom, 3'($urandom));
      if (bus.req_valid == '0) begin
        #1;
        chk("none_ready", bus.req_ready, '0);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid[$urandom_range(0, N - 1)] = 1'b1;
      end
      transact(1'b1, $urandom_range(0, 3), w);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
